pwm_3lmod: RTL and testbench



---
 rtl/PKG_decoder_3lxnpc.sv | 17 +
 rtl/tri_carrier.sv | 62 ++++++
 rtl/pwm_3lmod.sv | 84 ++++++++
 tb/tb_pwm_3lmod.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/PKG_decoder_3lxnpc.sv
// Shared types for the 3-level modulator and the NPC/NPP/ANPC switch-state decoders.
package PKG_decoder_3lxnpc;

  localparam int CARRIER_WIDTH = 16;

  typedef enum logic [1:0] {
    VLEV_N = 2'b00,
    VLEV_O = 2'b01,
    VLEV_P = 2'b10
  } _vlev_t;

  typedef enum logic {
    CUP   = 1'b0,
    CDOWN = 1'b1
  } _cdir_t;

endpackage

// File: rtl/tri_carrier.sv
// Symmetric triangular carrier 0..M..1 with period 2M; strobes flag the edges
// whose next count is the valley (0) or the peak (M).
module tri_carrier
  import PKG_decoder_3lxnpc::*;
#(
  parameter int CNT_WIDTH = CARRIER_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] max_sh,
  output logic [CNT_WIDTH-1:0] c,
  output _cdir_t               dir,
  output logic                 valley,
  output logic                 peak
);

  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] c_reg, c_next;
  _cdir_t               dir_reg, dir_next;

  always_comb begin
    c_next   = c_reg;
    dir_next = dir_reg;
    if (!en || max_sh == '0) begin
      c_next   = '0;
      dir_next = CUP;
    end else if (dir_reg == CUP) begin
      // >= rather than == so a stale count can never run past the peak
      if (c_reg >= max_sh - ONE) begin
        c_next   = max_sh;
        dir_next = CDOWN;
      end else begin
        c_next = c_reg + ONE;
      end
    end else begin
      if (c_reg <= ONE) begin
        c_next   = '0;
        dir_next = CUP;
      end else begin
        c_next = c_reg - ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_reg   <= '0;
      dir_reg <= CUP;
    end else begin
      c_reg   <= c_next;
      dir_reg <= dir_next;
    end
  end

  assign c      = c_reg;
  assign dir    = dir_reg;
  assign valley = (c_next == '0);
  assign peak   = (max_sh != '0) && (c_next == max_sh);

endmodule

// File: rtl/pwm_3lmod.sv
// Three-level phase-disposition PWM: shadow-buffered reference vs. triangular
// carrier, registered 2-bit level command (N/O/P) plus valley sync pulse.
module pwm_3lmod
  import PKG_decoder_3lxnpc::*;
#(
  parameter int CNT_WIDTH = CARRIER_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [CNT_WIDTH-1:0]        carrier_max,
  input  logic signed [CNT_WIDTH:0]   ref_val,
  input  logic                        upd_mode,
  output logic [1:0]                  v_lev,
  output logic                        sync
);

  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0]      c;
  _cdir_t                    dir;
  logic                      valley, peak;

  logic signed [CNT_WIDTH:0] ref_sh_reg;
  logic [CNT_WIDTH-1:0]      max_sh_reg;
  logic signed [CNT_WIDTH:0] max_s, ref_clamp;
  logic [CNT_WIDTH-1:0]      r;
  logic                      active;
  _vlev_t                    lev_next, v_lev_reg;
  logic                      sync_reg;

  tri_carrier #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_carrier (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .max_sh (max_sh_reg),
    .c      (c),
    .dir    (dir),
    .valley (valley),
    .peak   (peak)
  );

  always_comb begin
    max_s = signed'({1'b0, max_sh_reg});
    if (ref_sh_reg > max_s) begin
      ref_clamp = max_s;
    end else if (ref_sh_reg < -max_s) begin
      ref_clamp = -max_s;
    end else begin
      ref_clamp = ref_sh_reg;
    end
    // magnitude always fits CNT_WIDTH bits once clamped to +/-max_sh
    r = ref_clamp[CNT_WIDTH] ? (~ref_clamp[CNT_WIDTH-1:0] + ONE) : ref_clamp[CNT_WIDTH-1:0];
    active = (dir == CUP) ? (r > c) : ((r >= c) && (c != '0));
    lev_next = VLEV_O;
    if (active) begin
      lev_next = ref_sh_reg[CNT_WIDTH] ? VLEV_N : VLEV_P;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_sh_reg <= '0;
      max_sh_reg <= '0;
      v_lev_reg  <= VLEV_O;
      sync_reg   <= 1'b0;
    end else begin
      if (valley) begin
        ref_sh_reg <= ref_val;
        max_sh_reg <= carrier_max;
      end else if (peak && upd_mode) begin
        ref_sh_reg <= ref_val;
      end
      v_lev_reg <= en ? lev_next : VLEV_O;
      sync_reg  <= en && (c == '0) && (max_sh_reg != '0);
    end
  end

  assign v_lev = v_lev_reg;
  assign sync  = sync_reg;

endmodule

// File: tb/tb_pwm_3lmod.sv
// Directed and randomized checks of pwm_3lmod against a phase-index reference model.
module tb_pwm_3lmod;

  localparam int W = 16;

  logic                clk;
  logic                rst;
  logic                en;
  logic [W-1:0]        carrier_max;
  logic signed [W:0]   ref_val;
  logic                upd_mode;
  logic [1:0]          v_lev;
  logic                sync;

  int tests = 0;
  int fails = 0;

  // reference model: phase index within the 2M-clock period plus latched M/ref
  int mk = 0;
  int mm = 0;
  int mr = 0;
  logic [1:0] exp_v;
  logic       exp_s;
  logic [1:0] pat [8];

  pwm_3lmod #(
    .CNT_WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .carrier_max (carrier_max),
    .ref_val     (ref_val),
    .upd_mode    (upd_mode),
    .v_lev       (v_lev),
    .sync        (sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // active for the first r and last r clocks of a 2M period (duty r/M, centred on the valley)
  function automatic logic [1:0] model_level(input int k, input int m, input int rv);
    int cl;
    int r;
    cl = rv;
    if (cl > m) cl = m;
    if (cl < -m) cl = -m;
    r = (cl < 0) ? -cl : cl;
    if (r > 0 && (k < r || k >= 2 * m - r)) return (rv >= 0) ? 2'b10 : 2'b00;
    return 2'b01;
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      exp_v = 2'b01; exp_s = 1'b0;
      mk = 0; mm = 0; mr = 0;
    end else if (!en) begin
      exp_v = 2'b01; exp_s = 1'b0;
      mk = 0; mm = int'(carrier_max); mr = int'(ref_val);
    end else begin
      exp_v = model_level(mk, mm, mr);
      exp_s = (mk == 0) && (mm != 0);
      if (mm == 0) begin
        mk = 0; mm = int'(carrier_max); mr = int'(ref_val);
      end else begin
        mk = (mk + 1) % (2 * mm);
        if (mk == 0) begin
          mm = int'(carrier_max); mr = int'(ref_val);
        end else if (upd_mode && mk == mm) begin
          mr = int'(ref_val);
        end
      end
    end
    #1;
    check("model_v_lev", v_lev, exp_v);
    check("model_sync", {1'b0, sync}, {1'b0, exp_s});
  endtask

  task automatic wait_sync(input string tag);
    int n;
    n = 0;
    step();
    while (sync !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    tests++;
    assert (sync === 1'b1) else begin
      fails++;
      $error("FAIL %s: observed no sync pulse, expected one within 40 clocks", tag);
    end
  endtask

  task automatic settle(input string tag);
    wait_sync(tag);
    wait_sync(tag);
  endtask

  task automatic check_seq(input string tag, input logic [1:0] p [8], input int n, input bit now);
    for (int i = 0; i < n; i++) begin
      if (i > 0 || !now) step();
      check(tag, v_lev, p[i]);
    end
  endtask

  task automatic check_const(input string tag, input logic [1:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check(tag, v_lev, val);
    end
  endtask

  initial begin
    int t;
    rst = 1'b1; en = 1'b0; carrier_max = '0; ref_val = '0; upd_mode = 1'b0;
    step();
    check("reset_v_lev", v_lev, 2'b01);
    check("reset_sync", {1'b0, sync}, 2'b00);
    step();
    rst = 1'b0;
    carrier_max = 16'd4; ref_val = 17'sd9; en = 1'b1;
    wait_sync("start");
    check_const("const_p", 2'b10, 16);

    // asynchronous reset while driving P
    #2 rst = 1'b1;
    #1;
    check("async_rst_v_lev", v_lev, 2'b01);
    check("async_rst_sync", {1'b0, sync}, 2'b00);
    mk = 0; mm = 0; mr = 0;
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_rel_nosync", {1'b0, sync}, 2'b00);
    step();
    check("rst_rel_sync", {1'b0, sync}, 2'b01);

    ref_val = 17'sd2;
    settle("ref_p2");
    pat = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
    check_seq("pat_p2", pat, 8, 1'b1);

    ref_val = -17'sd3;
    settle("ref_n3");
    pat = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    check_seq("pat_n3", pat, 8, 1'b1);

    ref_val = -17'sd9;
    settle("ref_n9");
    check_const("const_n", 2'b00, 16);
    ref_val = 17'sd0;
    settle("ref_0");
    check_const("const_o_ref0", 2'b01, 16);

    carrier_max = 16'd0; ref_val = 17'sd5;
    repeat (12) step();
    check_const("const_o_m0", 2'b01, 12);

    // mid-period change, valley-only update
    carrier_max = 16'd4; ref_val = 17'sd2; upd_mode = 1'b0;
    settle("mid0");
    step();
    ref_val = -17'sd1;
    wait_sync("mid0_next");
    pat = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    check_seq("mid_upd0", pat, 8, 1'b1);

    // mid-period change, valley-and-peak update
    ref_val = 17'sd2; upd_mode = 1'b1;
    settle("mid1");
    step();
    ref_val = -17'sd1;
    step();
    step();
    pat = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
    check_seq("mid_upd1", pat, 4, 1'b0);

    // enable dropped for 5 cycles mid-period
    ref_val = 17'sd2; upd_mode = 1'b0;
    settle("en");
    step();
    step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("en_low_v_lev", v_lev, 2'b01);
      check("en_low_sync", {1'b0, sync}, 2'b00);
    end
    en = 1'b1;
    step();
    check("en_rise_sync", {1'b0, sync}, 2'b01);
    check("en_rise_v_lev", v_lev, 2'b10);

    // randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0: carrier_max = 16'($urandom_range(0, 7));
          1: begin
            t = int'($urandom_range(0, 20)) - 10;
            ref_val = t[W:0];
          end
          2: upd_mode = 1'($urandom_range(0, 1));
          default: en = ($urandom_range(0, 5) != 0);
        endcase
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
